clock_time_keeper: RTL and testbench

//   Consumer end of the 1 ms tick interface. Accumulates one-cycle millisecond strobes from the
//   ms-pulse counter into a 24-hour time of day (hh:mm:ss.mmm) and emits second/minute strobes.

---
 rtl/clock_pkg.sv | 20 ++
 rtl/clock_time_keeper_mod_n_counter.sv | 25 ++
 rtl/clock_time_keeper.sv | 91 +++++++++
 tb/tb_clock_time_keeper.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared time-of-day definitions for the clock datapath, display and alarm blocks.
// Field widths, rollover limits, keeper FSM states and the set-request layout.
package clock_pkg;
  localparam int HOUR_W         = 5;
  localparam int MIN_W          = 6;
  localparam int SEC_W          = 6;
  localparam int MS_W           = 10;
  localparam int MS_PER_SEC_DEF = 1000;
  localparam int HOURS_DEF      = 24;
  localparam int SEC_LIM        = 59;
  localparam int MIN_LIM        = 59;

  typedef enum logic [1:0] {STOP, RUN, LOAD} state_e;

  typedef struct packed {
    logic [HOUR_W-1:0] hour;
    logic [MIN_W-1:0]  min;
    logic [SEC_W-1:0]  sec;
  } set_req_t;
endpackage

// File: rtl/clock_time_keeper_mod_n_counter.sv
// Modulo-(LIMIT+1) counter with synchronous load.
// o_wrap is combinational so a chain of these carries through every stage in one cycle.
module mod_n_counter #(
  parameter int WIDTH = 6,
  parameter int LIMIT = 59
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_inc,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  output logic [WIDTH-1:0] o_val,
  output logic             o_wrap
);
  logic at_lim;

  assign at_lim = (o_val == WIDTH'(LIMIT));
  assign o_wrap = i_inc & at_lim & ~i_load;

  always_ff @(posedge i_clk) begin
    if (i_rst)       o_val <= '0;
    else if (i_load) o_val <= i_load_val;
    else if (i_inc)  o_val <= at_lim ? '0 : o_val + 1'b1;
  end
endmodule

// File: rtl/clock_time_keeper.sv
// Turns 1 ms strobes into a 24-hour hh:mm:ss.mmm time of day with second/minute strobes.
// The set interface captures a request, spends one LOAD cycle applying or rejecting it.
module clock_time_keeper
  import clock_pkg::*;
#(
  parameter int P_MS_PER_SEC = MS_PER_SEC_DEF,
  parameter int P_HOURS      = HOURS_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_ms_pulse,
  input  logic              i_run,
  input  logic              i_set_valid,
  input  logic [HOUR_W-1:0] i_set_hour,
  input  logic [MIN_W-1:0]  i_set_min,
  input  logic [SEC_W-1:0]  i_set_sec,
  output logic              o_set_ready,
  output logic              o_set_error,
  output logic [HOUR_W-1:0] o_hour,
  output logic [MIN_W-1:0]  o_min,
  output logic [SEC_W-1:0]  o_sec,
  output logic [MS_W-1:0]   o_ms,
  output logic              o_sec_pulse,
  output logic              o_min_pulse
);
  state_e   state, state_nxt;
  set_req_t set_q;
  logic     set_xfer, set_in_range, load_ok, tick;
  logic     ms_wrap, sec_wrap, min_wrap, hour_wrap_unused;

  assign set_xfer     = i_set_valid & o_set_ready;
  assign set_in_range = (int'(i_set_hour) < P_HOURS) && (int'(i_set_min) <= MIN_LIM) &&
                        (int'(i_set_sec) <= SEC_LIM);
  // A tick that lands on the handshake cycle is dropped; the set wins.
  assign tick         = i_ms_pulse & (state == RUN) & ~set_xfer;

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= STOP;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (set_xfer) state_nxt = LOAD;
    else begin
      case (state)
        STOP, RUN, LOAD: state_nxt = i_run ? RUN : STOP;
        default:         state_nxt = STOP;
      endcase
    end
  end

  always_comb begin
    o_set_ready = (state != LOAD);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      load_ok     <= 1'b0;
      o_set_error <= 1'b0;
      o_sec_pulse <= 1'b0;
      o_min_pulse <= 1'b0;
    end else begin
      load_ok     <= set_xfer & set_in_range;
      o_set_error <= set_xfer & ~set_in_range;
      o_sec_pulse <= ms_wrap;
      o_min_pulse <= sec_wrap;
    end
  end

  always_ff @(posedge i_clk) begin
    if (set_xfer) set_q <= {i_set_hour, i_set_min, i_set_sec};
  end

  mod_n_counter #(.WIDTH(MS_W), .LIMIT(P_MS_PER_SEC - 1)) u_ms (
    .i_clk(i_clk), .i_rst(i_rst), .i_inc(tick), .i_load(load_ok),
    .i_load_val('0), .o_val(o_ms), .o_wrap(ms_wrap));

  mod_n_counter #(.WIDTH(SEC_W), .LIMIT(SEC_LIM)) u_sec (
    .i_clk(i_clk), .i_rst(i_rst), .i_inc(ms_wrap), .i_load(load_ok),
    .i_load_val(set_q.sec), .o_val(o_sec), .o_wrap(sec_wrap));

  mod_n_counter #(.WIDTH(MIN_W), .LIMIT(MIN_LIM)) u_min (
    .i_clk(i_clk), .i_rst(i_rst), .i_inc(sec_wrap), .i_load(load_ok),
    .i_load_val(set_q.min), .o_val(o_min), .o_wrap(min_wrap));

  // Midnight rollover needs no strobe of its own.
  mod_n_counter #(.WIDTH(HOUR_W), .LIMIT(P_HOURS - 1)) u_hour (
    .i_clk(i_clk), .i_rst(i_rst), .i_inc(min_wrap), .i_load(load_ok),
    .i_load_val(set_q.hour), .o_val(o_hour), .o_wrap(hour_wrap_unused));
endmodule

// File: tb/tb_clock_time_keeper.sv
// Directed scenarios plus a random phase; the reference keeps time as total milliseconds of day.
module tb_clock_time_keeper;
  localparam int unsigned DAY = 24 * 3600 * 1000;
  localparam int M_STOP = 0, M_RUN = 1, M_LOAD = 2;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1, i_ms_pulse = 1'b0, i_run = 1'b0, i_set_valid = 1'b0;
  logic [4:0] i_set_hour = '0;
  logic [5:0] i_set_min = '0, i_set_sec = '0;
  logic       o_set_ready, o_set_error, o_sec_pulse, o_min_pulse;
  logic [4:0] o_hour;
  logic [5:0] o_min, o_sec;
  logic [9:0] o_ms;

  clock_time_keeper dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_ms_pulse(i_ms_pulse), .i_run(i_run),
    .i_set_valid(i_set_valid), .i_set_hour(i_set_hour), .i_set_min(i_set_min),
    .i_set_sec(i_set_sec), .o_set_ready(o_set_ready), .o_set_error(o_set_error),
    .o_hour(o_hour), .o_min(o_min), .o_sec(o_sec), .o_ms(o_ms),
    .o_sec_pulse(o_sec_pulse), .o_min_pulse(o_min_pulse));

  always #5 i_clk = ~i_clk;

  int          vectors = 0, miscompares = 0;
  int unsigned m_total = 0, m_pend = 0;
  int          m_mode = M_STOP;
  bit          m_pend_ok, m_secp, m_minp, m_err, m_xfer;
  int          sp_cnt = 0;
  bit          both_seen = 0;

  // Reference: advance the model by one clock edge using the inputs sampled at that edge.
  task automatic model_edge();
    int unsigned old;
    m_xfer = 0; m_secp = 0; m_minp = 0; m_err = 0;
    if (i_rst) begin
      m_total = 0; m_mode = M_STOP; m_pend_ok = 0;
    end else if (i_set_valid && m_mode != M_LOAD) begin
      m_xfer    = 1;
      m_mode    = M_LOAD;
      m_pend_ok = (int'(i_set_hour) < 24) && (int'(i_set_min) < 60) && (int'(i_set_sec) < 60);
      m_pend    = ((int'(i_set_hour) * 60 + int'(i_set_min)) * 60 + int'(i_set_sec)) * 1000;
      m_err     = !m_pend_ok;
    end else if (m_mode == M_LOAD) begin
      if (m_pend_ok) m_total = m_pend;
      m_mode = i_run ? M_RUN : M_STOP;
    end else begin
      if (m_mode == M_RUN && i_ms_pulse) begin
        old     = m_total;
        m_total = (m_total + 1) % DAY;
        m_secp  = (m_total / 1000) != (old / 1000);
        m_minp  = (m_total / 60000) != (old / 60000);
      end
      m_mode = i_run ? M_RUN : M_STOP;
    end
  endtask

  task automatic check_vec(input string tag);
    logic [30:0] act, exp;
    act = {o_hour, o_min, o_sec, o_ms, o_sec_pulse, o_min_pulse, o_set_ready, o_set_error};
    exp = {5'(m_total / 3600000), 6'((m_total / 60000) % 60), 6'((m_total / 1000) % 60),
           10'(m_total % 1000), m_secp, m_minp, (m_mode != M_LOAD), m_err};
    vectors++;
    assert (act === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h (%0d:%0d:%0d.%0d) expected %h", tag, act,
             o_hour, o_min, o_sec, o_ms, exp);
    end
  endtask

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag);
    @(posedge i_clk);
    model_edge();
    #1;
    if (o_sec_pulse) sp_cnt++;
    if (o_sec_pulse && o_min_pulse) both_seen = 1;
    check_vec(tag);
  endtask

  task automatic ticks(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      i_ms_pulse = 1'b1; step(tag);
      i_ms_pulse = 1'b0; step(tag);
    end
  endtask

  // Hold the request until accepted (bounded), then step through the LOAD cycle.
  task automatic do_set(input int h, input int m, input int s, input logic pulse,
                        input string tag);
    int k = 0;
    bit done = 0;
    i_set_valid = 1'b1; i_set_hour = 5'(h); i_set_min = 6'(m); i_set_sec = 6'(s);
    i_ms_pulse  = pulse;
    while (!done && k < 4) begin
      step(tag);
      done = m_xfer;
      k++;
    end
    i_set_valid = 1'b0; i_ms_pulse = 1'b0;
    check_val({tag, "_accepted"}, 32'(done), 32'd1);
    step(tag);
  endtask

  initial begin
    // Reset
    i_rst = 1'b1;
    step("reset"); step("reset");
    i_rst = 1'b0;
    step("idle_stop");

    // 1000 ticks from zero -> one second, single sec strobe
    i_run = 1'b1; step("run_en");
    sp_cnt = 0;
    ticks(1000, "first_sec");
    check_val("first_sec_pulses", 32'(sp_cnt), 32'd1);
    check_val("first_sec_val", {26'd0, o_sec}, 32'd1);

    // Midnight wrap
    do_set(23, 59, 59, 1'b0, "set_2359");
    both_seen = 0;
    ticks(1000, "midnight");
    check_val("midnight_both_strobes", 32'(both_seen), 32'd1);
    check_val("midnight_time", {5'd0, o_hour, o_min, o_sec, o_ms}, 32'd0);

    // Out-of-range set leaves time untouched
    do_set(1, 2, 3, 1'b0, "set_010203");
    ticks(456, "to_456");
    do_set(24, 10, 0, 1'b0, "bad_hour");
    check_val("bad_hour_ms", {22'd0, o_ms}, 32'd456);
    do_set(5, 60, 0, 1'b0, "bad_min");
    do_set(5, 0, 60, 1'b0, "bad_sec");

    // Ticks while stopped are dropped
    i_run = 1'b0; step("stop");
    ticks(50, "stopped_ticks");
    i_run = 1'b1; step("restart");
    ticks(5, "run_5");
    check_val("stop_ms", {22'd0, o_ms}, 32'd461);

    // Tick on the acceptance cycle is lost
    do_set(12, 0, 0, 1'b1, "set_noon_tick");
    check_val("noon_ms", {22'd0, o_ms}, 32'd0);
    ticks(1, "noon_plus1");
    check_val("noon_ms1", {22'd0, o_ms}, 32'd1);

    // Run deasserted together with a tick: still counted
    i_run = 1'b0; i_ms_pulse = 1'b1; step("run_drop_tick");
    i_ms_pulse = 1'b0; step("run_drop_after");
    i_run = 1'b1; step("run_again");

    // Reset in the LOAD cycle
    i_set_valid = 1'b1; i_set_hour = 5'd7; i_set_min = 6'd7; i_set_sec = 6'd7;
    step("rst_load_hs");
    i_set_valid = 1'b0; i_rst = 1'b1;
    step("rst_in_load");
    i_rst = 1'b0;
    step("after_rst_load");

    // Reset on a ms->sec carry
    i_run = 1'b1; step("run_en2");
    ticks(999, "to_999");
    i_ms_pulse = 1'b1; i_rst = 1'b1; step("rst_on_carry");
    i_ms_pulse = 1'b0; i_rst = 1'b0; step("after_rst_carry");

    // Random traffic
    do_set(23, 59, 58, 1'b0, "rand_seed_time");
    for (int c = 0; c < 3000; c++) begin
      i_rst       = ($urandom_range(0, 63) == 0);
      i_ms_pulse  = $urandom_range(0, 1) == 1;
      i_run       = ($urandom_range(0, 7) != 0);
      i_set_valid = ($urandom_range(0, 31) == 0);
      i_set_hour  = 5'($urandom_range(0, 26));
      i_set_min   = 6'($urandom_range(0, 63));
      i_set_sec   = 6'($urandom_range(0, 63));
      step("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
